// File: rtl/stripe_arbiter_pkg.sv
// Shared types and defaults for the stripe arbiter and its round-robin helper.
package stripe_arbiter_pkg;

  localparam int          DEF_DATA_W    = 32;
  localparam logic [31:0] DEF_IDLE_WORD = 32'h0000_00BC;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    BURST = 2'd1,
    PAD   = 2'd2
  } state_t;

endpackage

// File: rtl/stripe_arbiter_rr_arbiter2.sv
// Two-request round-robin picker: prefers the requester that did not win last,
// and only grants while enable is high.
module rr_arbiter2 (
  input  logic       clk_2f,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_last;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req[0] && (rr_last || !req[1])) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end

  // rr_last resets to 1 so source 0 wins the first contest
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      rr_last <= 1'b1;
    end else if (gnt[0]) begin
      rr_last <= 1'b0;
    end else if (gnt[1]) begin
      rr_last <= 1'b1;
    end
  end

endmodule

// File: rtl/stripe_arbiter.sv
// Merges two fall-through sources into one word stream for the 2-lane striper,
// starting every burst on lane 0 and padding odd bursts to a full lane pair.
module stripe_arbiter
  import stripe_arbiter_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                MAX_BURST = 8,
  parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(DEF_IDLE_WORD)
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              src0_empty,
  input  logic [DATA_W-1:0] src0_data,
  output logic              src0_pop,
  input  logic              src1_empty,
  input  logic [DATA_W-1:0] src1_data,
  output logic              src1_pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              lane_phase,
  output logic [1:0]        grant,
  output logic              pad_out
);

  localparam int               CNT_W   = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  state_t            state;
  logic [CNT_W-1:0]  burst_count;
  logic [1:0]        req;
  logic [1:0]        arb_gnt;
  logic              arb_en;
  logic              owner_empty;
  logic              burst_pop;
  logic              any_pop;
  logic [DATA_W-1:0] pop_data;

  assign req         = {~src1_empty, ~src0_empty};
  assign owner_empty = grant[1] ? src1_empty : src0_empty;
  assign burst_pop   = (state == BURST) && !owner_empty && (burst_count < MAX_CNT);

  // Arbitration only on lane-1 cycles so the first popped word lands on lane 0;
  // a burst that stops popping on lane 1 hands over in that same cycle.
  assign arb_en = lane_phase && ((state != BURST) || !burst_pop);

  rr_arbiter2 u_rr (
    .clk_2f (clk_2f),
    .reset  (reset),
    .enable (arb_en),
    .req    (req),
    .gnt    (arb_gnt)
  );

  assign src0_pop = (burst_pop && grant[0]) || arb_gnt[0];
  assign src1_pop = (burst_pop && grant[1]) || arb_gnt[1];
  assign any_pop  = src0_pop || src1_pop;
  assign pop_data = src1_pop ? src1_data : src0_data;

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state       <= ARB;
      burst_count <= '0;
      grant       <= 2'b00;
      lane_phase  <= 1'b0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      pad_out     <= 1'b0;
    end else begin
      lane_phase <= ~lane_phase;
      valid_out  <= any_pop;
      data_out   <= any_pop ? pop_data : '0;
      pad_out    <= 1'b0;
      if (arb_gnt != 2'b00) begin
        state       <= BURST;
        grant       <= arb_gnt;
        burst_count <= CNT_W'(1);
      end else begin
        case (state)
          BURST: begin
            if (burst_pop) begin
              burst_count <= burst_count + 1'b1;
            end else if (lane_phase) begin
              state <= ARB;
              grant <= 2'b00;
            end else begin
              // Odd word count: fill lane 1 with the idle word
              state     <= PAD;
              data_out  <= IDLE_WORD;
              valid_out <= 1'b1;
              pad_out   <= 1'b1;
            end
          end
          default: begin
            state <= ARB;
            grant <= 2'b00;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stripe_arbiter.sv
// Scoreboard bench for stripe_arbiter: queue-modelled FIFOs feed the DUT,
// expected words are queued at stimulus time and checked by a monitor.
module tb_stripe_arbiter;

  typedef struct {
    logic [31:0] data;
    logic        phase;
    logic        pad;
    logic [1:0]  grant;
    logic        follows;
  } exp_t;

  logic        clk_2f = 1'b0;
  logic        reset  = 1'b1;
  logic        src0_empty, src1_empty;
  logic [31:0] src0_data, src1_data;
  logic        src0_pop, src1_pop;
  logic [31:0] data_out;
  logic        valid_out, lane_phase, pad_out;
  logic [1:0]  grant;

  logic [31:0] q0[$], q1[$], pend0[$], pend1[$];
  exp_t        exp_q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          words_seen = 0;
  logic        prev_valid = 1'b0;
  logic        phase_m = 1'b0;
  logic        p0, p1;

  always #5 clk_2f = ~clk_2f;

  stripe_arbiter #(
    .DATA_W    (32),
    .MAX_BURST (8),
    .IDLE_WORD (32'h0000_00BC)
  ) dut (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .src0_empty (src0_empty),
    .src0_data  (src0_data),
    .src0_pop   (src0_pop),
    .src1_empty (src1_empty),
    .src1_data  (src1_data),
    .src1_pop   (src1_pop),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .lane_phase (lane_phase),
    .grant      (grant),
    .pad_out    (pad_out)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_word(input logic [31:0] d, input logic ph, input logic pad,
                             input logic [1:0] g, input logic fol);
    exp_t x;
    x.data = d; x.phase = ph; x.pad = pad; x.grant = g; x.follows = fol;
    exp_q.push_back(x);
  endtask

  task automatic apply_stimulus(input int src, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (src == 0) pend0.push_back(base + 32'(i));
      else          pend1.push_back(base + 32'(i));
    end
  endtask

  task automatic do_reset();
    @(posedge clk_2f);
    #2 reset = 1'b1;
    #1;
    check_output("reset data_out",   data_out,         32'd0);
    check_output("reset valid_out",  32'(valid_out),   32'd0);
    check_output("reset lane_phase", 32'(lane_phase),  32'd0);
    check_output("reset grant",      32'(grant),       32'd0);
    check_output("reset pad_out",    32'(pad_out),     32'd0);
    exp_q.delete();
    pend0.delete();
    pend1.delete();
    repeat (2) @(posedge clk_2f);
    @(negedge clk_2f);
    #2 reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk_2f);
      c++;
    end
    @(negedge clk_2f);
    check_output("drain remaining", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle(input int n);
    repeat (n) begin
      @(negedge clk_2f);
      #1;
      check_output("idle valid_out", 32'(valid_out), 32'd0);
      check_output("idle grant",     32'(grant),     32'd0);
    end
  endtask

  // Source FIFO model: pops seen before the edge take effect just after it
  initial begin
    src0_empty = 1'b1; src1_empty = 1'b1;
    src0_data  = '0;   src1_data  = '0;
    forever begin
      @(negedge clk_2f);
      p0 = src0_pop;
      p1 = src1_pop;
      @(posedge clk_2f);
      #1;
      if (reset) begin
        q0.delete();
        q1.delete();
      end else begin
        if (p0 && q0.size() != 0) void'(q0.pop_front());
        if (p1 && q1.size() != 0) void'(q1.pop_front());
      end
      while (pend0.size() != 0) q0.push_back(pend0.pop_front());
      while (pend1.size() != 0) q1.push_back(pend1.pop_front());
      src0_empty = (q0.size() == 0);
      src1_empty = (q1.size() == 0);
      src0_data  = (q0.size() != 0) ? q0[0] : 32'd0;
      src1_data  = (q1.size() != 0) ? q1[0] : 32'd0;
    end
  end

  always @(posedge clk_2f) begin
    phase_m <= reset ? 1'b0 : ~phase_m;
  end

  // Monitor: lane phase and pop legality every cycle, scoreboard on each valid word
  always @(negedge clk_2f) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      check_output("lane_phase", 32'(lane_phase), 32'(phase_m));
      check_output("pop legality",
                   32'((src0_pop && src1_pop) || (src0_pop && src0_empty) || (src1_pop && src1_empty)),
                   32'd0);
      if (valid_out) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected word: got %h, expected none at %0t", data_out, $time);
        end else begin
          e = exp_q.pop_front();
          check_output("word data",  data_out,          e.data);
          check_output("word phase", 32'(lane_phase),   32'(e.phase));
          check_output("word pad",   32'(pad_out),      32'(e.pad));
          check_output("word grant", 32'(grant),        32'(e.grant));
          if (e.follows) check_output("bubble", 32'(prev_valid), 32'd1);
        end
      end
      prev_valid = valid_out;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start;
    int c;
    do_reset();

    // Idle: nothing to send
    check_idle(8);

    // Four words from source 0 only
    apply_stimulus(0, 32'hA000_0000, 4);
    for (int i = 0; i < 4; i++) expect_word(32'hA000_0000 + 32'(i), 1'(i % 2), 1'b0, 2'b01, i > 0);
    wait_drain(40);
    check_idle(2);

    // Three words: padded to a full pair
    pend0.push_back(32'h11); pend0.push_back(32'h22); pend0.push_back(32'h33);
    expect_word(32'h11, 1'b0, 1'b0, 2'b01, 1'b0);
    expect_word(32'h22, 1'b1, 1'b0, 2'b01, 1'b1);
    expect_word(32'h33, 1'b0, 1'b0, 2'b01, 1'b1);
    expect_word(32'hBC, 1'b1, 1'b1, 2'b01, 1'b1);
    wait_drain(40);
    check_idle(3);

    // Ten words each: 8/8 then 2/2 back-to-back
    do_reset();
    apply_stimulus(0, 32'hC000_0000, 10);
    apply_stimulus(1, 32'hD000_0000, 10);
    for (int i = 0; i < 8; i++) expect_word(32'hC000_0000 + 32'(i), 1'(i % 2), 1'b0, 2'b01, i > 0);
    for (int i = 0; i < 8; i++) expect_word(32'hD000_0000 + 32'(i), 1'(i % 2), 1'b0, 2'b10, 1'b1);
    for (int i = 8; i < 10; i++) expect_word(32'hC000_0000 + 32'(i), 1'(i % 2), 1'b0, 2'b01, 1'b1);
    for (int i = 8; i < 10; i++) expect_word(32'hD000_0000 + 32'(i), 1'(i % 2), 1'b0, 2'b10, 1'b1);
    wait_drain(100);
    check_idle(2);

    // Source fills during a lane-0 cycle: grant waits for lane 1
    c = 0;
    do begin
      @(negedge clk_2f);
      c++;
    end while (lane_phase != 1'b1 && c < 4);
    apply_stimulus(0, 32'h5A5A_0001, 2);
    expect_word(32'h5A5A_0001, 1'b0, 1'b0, 2'b01, 1'b0);
    expect_word(32'h5A5A_0002, 1'b1, 1'b0, 2'b01, 1'b1);
    @(negedge clk_2f);
    #1;
    check_output("late fill phase", 32'(lane_phase), 32'd0);
    check_output("late fill pop",   32'(src0_pop),   32'd0);
    @(negedge clk_2f);
    #1;
    check_output("late fill grant pop", 32'(src0_pop), 32'd1);
    wait_drain(40);
    check_idle(2);

    // Reset after three words of a burst, then source 0 must win again
    do_reset();
    apply_stimulus(0, 32'hE000_0000, 8);
    for (int i = 0; i < 8; i++) expect_word(32'hE000_0000 + 32'(i), 1'(i % 2), 1'b0, 2'b01, i > 0);
    start = words_seen;
    c = 0;
    while (words_seen < start + 3 && c < 40) begin
      @(negedge clk_2f);
      c++;
    end
    check_output("words before reset", 32'(words_seen >= start + 3), 32'd1);
    do_reset();
    apply_stimulus(0, 32'hF000_0000, 2);
    apply_stimulus(1, 32'hF100_0000, 2);
    expect_word(32'hF000_0000, 1'b0, 1'b0, 2'b01, 1'b0);
    expect_word(32'hF000_0001, 1'b1, 1'b0, 2'b01, 1'b1);
    expect_word(32'hF100_0000, 1'b0, 1'b0, 2'b10, 1'b1);
    expect_word(32'hF100_0001, 1'b1, 1'b0, 2'b10, 1'b1);
    wait_drain(40);
    check_idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
